// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared constants for the Display_Module BCD/binary datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int DEFAULT_DIGITS    = 4;
    localparam int DEFAULT_BIN_WIDTH = 16;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_MAX_DIGIT = 9;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bcd_to_binary_converter_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_binary_converter_if
// Description : Start/busy/done request bundle for the BCD-to-binary converter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_to_binary_converter_if
    import display_pkg::*;
#(
    parameter int DIGITS    = DEFAULT_DIGITS,
    parameter int BIN_WIDTH = DEFAULT_BIN_WIDTH
);

    logic                   start;
    logic [4*DIGITS-1:0]    bcd_number;
    logic                   busy;
    logic                   done;
    logic [BIN_WIDTH-1:0]   binary_number;
    logic                   error;

    modport master (
        output start,
        output bcd_number,
        input  busy,
        input  done,
        input  binary_number,
        input  error
    );

    modport slave (
        input  start,
        input  bcd_number,
        output busy,
        output done,
        output binary_number,
        output error
    );

endinterface
`default_nettype wire

// File: rtl/bcd_to_binary_converter_mul10_add.sv
`default_nettype none
// ============================================================================
// Module      : bcd_mul10_add
// Description : One Horner step, acc*10 + digit, wrapping modulo 2^BIN_WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_mul10_add
    import display_pkg::*;
#(
    parameter int BIN_WIDTH = DEFAULT_BIN_WIDTH
) (
    input  wire logic [BIN_WIDTH-1:0]   acc,
    input  wire logic [BCD_DIGIT_W-1:0] digit,
    output logic      [BIN_WIDTH-1:0]   result
);

    // Shift-and-add keeps the multiply out of the critical path.
    assign result = (acc << 3) + (acc << 1) + BIN_WIDTH'(digit);

endmodule
`default_nettype wire

// File: rtl/bcd_to_binary_converter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_binary_converter
// Description : Sequential packed-BCD to binary converter, one digit per
//               clock, MSD first. Optional macro BCD_CHECK_EN rejects
//               non-decimal digits at accept with a one-cycle error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_binary_converter
    import display_pkg::*;
#(
    parameter int DIGITS    = DEFAULT_DIGITS,
    parameter int BIN_WIDTH = DEFAULT_BIN_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    bcd_to_binary_converter_if.slave   bus
);

    localparam int c_CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_BCD_W  = BCD_DIGIT_W * DIGITS;

    logic [0:0]             r_state;
    logic [BIN_WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_BCD_W-1:0]     r_shift;
    logic                   r_busy;
    logic                   r_done;
    logic [BIN_WIDTH-1:0]   r_result;

    logic [BIN_WIDTH-1:0]   w_acc_next;
    logic                   w_bad_digit;
    logic                   w_last;

    bcd_mul10_add #(
        .BIN_WIDTH (BIN_WIDTH)
    ) u_mul10_add (
        .acc    (r_acc),
        .digit  (r_shift[c_BCD_W-1 -: BCD_DIGIT_W]),
        .result (w_acc_next)
    );

    assign w_last = (r_cnt == c_CNT_W'(DIGITS - 1));

`ifdef BCD_CHECK_EN
    logic r_error;

    always_comb begin
        w_bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_number[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT))
                w_bad_digit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_error <= 1'b0;
        else
            r_error <= (r_state == ST_IDLE) && bus.start && w_bad_digit;
    end

    assign bus.error = r_error;
`else
    // Without checking, out-of-range digits simply flow through the arithmetic.
    assign w_bad_digit = 1'b0;
    assign bus.error   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (w_bad_digit) begin
                            r_done   <= 1'b1;
                            r_result <= '0;
                        end else begin
                            r_shift <= bus.bcd_number;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_CONV;
                        end
                    end
                end
                ST_CONV: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift << BCD_DIGIT_W;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_acc_next;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.binary_number = r_result;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_binary_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_to_binary_converter
// Description : Directed self-checking bench for bcd_to_binary_converter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_binary_converter;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int total = 0;
    int bad   = 0;

    bcd_to_binary_converter_if #(.DIGITS(4), .BIN_WIDTH(16)) bus ();

    bcd_to_binary_converter #(
        .DIGITS    (4),
        .BIN_WIDTH (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch a conversion and verify the busy/done timeline and the result.
    task automatic run_conv(input logic [15:0] bcd, input logic [15:0] exp, input string tag);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.bcd_number = bcd;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s busy c%0d", tag, k), {31'd0, bus.busy}, 32'd1);
            check($sformatf("%s done c%0d", tag, k), {31'd0, bus.done}, 32'd0);
            @(negedge clk);
        end
        check({tag, " done"},   {31'd0, bus.done},  32'd1);
        check({tag, " busy@d"}, {31'd0, bus.busy},  32'd0);
        check({tag, " error"},  {31'd0, bus.error}, 32'd0);
        check({tag, " result"}, {16'd0, bus.binary_number}, {16'd0, exp});
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.bcd_number = '0;

        vecs[0] = '{16'h1234, 16'h04D2};
        vecs[1] = '{16'h9999, 16'h270F};
        vecs[2] = '{16'h0000, 16'h0000};
        vecs[3] = '{16'h0009, 16'h0009};
        vecs[4] = '{16'h5678, 16'h162E};
        vecs[5] = '{16'h0807, 16'h0327};

        repeat (3) @(negedge clk);
        check("reset busy",   {31'd0, bus.busy},  32'd0);
        check("reset done",   {31'd0, bus.done},  32'd0);
        check("reset error",  {31'd0, bus.error}, 32'd0);
        check("reset result", {16'd0, bus.binary_number}, 32'd0);
        reset = 1'b0;

        // Test 1 then hold check
        run_conv(vecs[0].bcd, vecs[0].exp, "t1");
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("hold done %0d", k),   {31'd0, bus.done}, 32'd0);
            check($sformatf("hold result %0d", k), {16'd0, bus.binary_number}, 32'h04D2);
        end

        for (int i = 1; i < 6; i++)
            run_conv(vecs[i].bcd, vecs[i].exp, $sformatf("vec%0d", i));

        // Test 3: start held during busy, back-to-back accept in the done cycle
        @(negedge clk);
        bus.start      = 1'b1;
        bus.bcd_number = 16'h0500;
        @(negedge clk);
        bus.bcd_number = 16'h0001;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3 busy c%0d", k), {31'd0, bus.busy}, 32'd1);
            check($sformatf("t3 done c%0d", k), {31'd0, bus.done}, 32'd0);
            @(negedge clk);
        end
        check("t3 first done",   {31'd0, bus.done}, 32'd1);
        check("t3 first result", {16'd0, bus.binary_number}, 32'h01F4);
        bus.bcd_number = 16'h0042;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3b busy c%0d", k), {31'd0, bus.busy}, 32'd1);
            check($sformatf("t3b done c%0d", k), {31'd0, bus.done}, 32'd0);
            @(negedge clk);
        end
        check("t3 second done",   {31'd0, bus.done}, 32'd1);
        check("t3 second result", {16'd0, bus.binary_number}, 32'h002A);
        @(negedge clk);
        check("t3 done width", {31'd0, bus.done}, 32'd0);

        // Test 4: reset in the second CONV cycle aborts the conversion
        @(negedge clk);
        bus.start      = 1'b1;
        bus.bcd_number = 16'h1234;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t4 busy %0d", k),   {31'd0, bus.busy}, 32'd0);
            check($sformatf("t4 done %0d", k),   {31'd0, bus.done}, 32'd0);
            check($sformatf("t4 result %0d", k), {16'd0, bus.binary_number}, 32'd0);
            @(negedge clk);
        end
        run_conv(16'h0100, 16'h0064, "t4 after");

        // Test 5: non-decimal digit
`ifdef BCD_CHECK_EN
        @(negedge clk);
        bus.start      = 1'b1;
        bus.bcd_number = 16'h12A4;
        @(negedge clk);
        bus.start = 1'b0;
        check("t5 done",   {31'd0, bus.done},  32'd1);
        check("t5 error",  {31'd0, bus.error}, 32'd1);
        check("t5 busy",   {31'd0, bus.busy},  32'd0);
        check("t5 result", {16'd0, bus.binary_number}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("t5 busy %0d", k),  {31'd0, bus.busy},  32'd0);
            check($sformatf("t5 done %0d", k),  {31'd0, bus.done},  32'd0);
            check($sformatf("t5 error %0d", k), {31'd0, bus.error}, 32'd0);
        end
`else
        run_conv(16'h12A4, 16'h0518, "t5");
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
